// File: rtl/sensor_direction_decoder.sv
// Two-beam passage decoder: synchronizes and debounces the outer (A) and
// inner (B) beam sensors, then tracks A->B entries and B->A exits.
// Ports:
//   clkup      clock, all state on rising edge
//   reset      synchronous active-high reset
//   sens_a     raw outer beam (1 = broken), asynchronous
//   sens_b     raw inner beam (1 = broken), asynchronous
//   inc_pulse  one-cycle pulse per completed entry
//   dec_pulse  one-cycle pulse per completed exit
//   up_dn      last completed direction (1 = up)
//   busy       passage in progress
//   err_pulse  one-cycle pulse on illegal sequence or timeout
module sensor_direction_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic clkup,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic up_dn,
  output logic busy,
  output logic err_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, A1, AB_A, B2, B1, AB_B, A2, WAIT_CLR
  } state_t;

  logic          sa_m, sa_s, sb_m, sb_s;
  logic          fa, fb;
  logic [DW-1:0] cnt_a, cnt_b;
  logic [TW-1:0] dwell;
  state_t        state, nxt;
  logic          inc_n, dec_n, err_n;
  logic          active;

  // Filtered value moves only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clkup) begin
    if (reset) begin
      sa_m  <= 1'b0;
      sa_s  <= 1'b0;
      sb_m  <= 1'b0;
      sb_s  <= 1'b0;
      fa    <= 1'b0;
      fb    <= 1'b0;
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      sa_m <= sens_a;
      sa_s <= sa_m;
      sb_m <= sens_b;
      sb_s <= sb_m;
      if (sa_s == fa) begin
        cnt_a <= '0;
      end else if (cnt_a == DW'(DEBOUNCE_CYCLES - 1)) begin
        fa    <= sa_s;
        cnt_a <= '0;
      end else begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (sb_s == fb) begin
        cnt_b <= '0;
      end else if (cnt_b == DW'(DEBOUNCE_CYCLES - 1)) begin
        fb    <= sb_s;
        cnt_b <= '0;
      end else begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

  assign active = (state != IDLE) && (state != WAIT_CLR);

  always_comb begin
    nxt   = state;
    inc_n = 1'b0;
    dec_n = 1'b0;
    err_n = 1'b0;
    unique case (state)
      IDLE: begin
        case ({fa, fb})
          2'b10:   nxt = A1;
          2'b01:   nxt = B1;
          2'b11:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = IDLE;
        endcase
      end
      A1: begin
        case ({fa, fb})
          2'b11:   nxt = AB_A;
          2'b00:   nxt = IDLE;
          2'b01:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = A1;
        endcase
      end
      AB_A: begin
        case ({fa, fb})
          2'b01:   nxt = B2;
          2'b10:   nxt = A1;
          2'b00:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = AB_A;
        endcase
      end
      B2: begin
        case ({fa, fb})
          2'b00:   begin nxt = IDLE; inc_n = 1'b1; end
          2'b11:   nxt = AB_A;
          2'b10:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = B2;
        endcase
      end
      B1: begin
        case ({fa, fb})
          2'b11:   nxt = AB_B;
          2'b00:   nxt = IDLE;
          2'b10:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = B1;
        endcase
      end
      AB_B: begin
        case ({fa, fb})
          2'b10:   nxt = A2;
          2'b01:   nxt = B1;
          2'b00:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = AB_B;
        endcase
      end
      A2: begin
        case ({fa, fb})
          2'b00:   begin nxt = IDLE; dec_n = 1'b1; end
          2'b11:   nxt = AB_B;
          2'b01:   begin nxt = WAIT_CLR; err_n = 1'b1; end
          default: nxt = A2;
        endcase
      end
      WAIT_CLR: begin
        if ({fa, fb} == 2'b00) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Timeout only fires when the sensors would otherwise keep us in place.
    if (active && nxt == state && dwell == TW'(TIMEOUT_CYCLES - 1)) begin
      nxt   = WAIT_CLR;
      err_n = 1'b1;
    end
  end

  always_ff @(posedge clkup) begin
    if (reset) begin
      state     <= IDLE;
      dwell     <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      err_pulse <= 1'b0;
      busy      <= 1'b0;
      up_dn     <= 1'b1;
    end else begin
      state     <= nxt;
      inc_pulse <= inc_n;
      dec_pulse <= dec_n;
      err_pulse <= err_n;
      busy      <= (nxt != IDLE);
      if (nxt != state) begin
        dwell <= '0;
      end else if (dwell != TW'(TIMEOUT_CYCLES)) begin
        dwell <= dwell + 1'b1;
      end
      if (inc_n) begin
        up_dn <= 1'b1;
      end else if (dec_n) begin
        up_dn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sensor_direction_decoder.sv
// Directed bench for sensor_direction_decoder with default parameters.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_sensor_direction_decoder;

  logic clkup = 1'b0;
  logic reset;
  logic sens_a;
  logic sens_b;
  logic inc_pulse;
  logic dec_pulse;
  logic up_dn;
  logic busy;
  logic err_pulse;

  int checks = 0;
  int errors = 0;
  int n_inc = 0;
  int n_dec = 0;
  int n_err = 0;
  int n_multi = 0;
  int b_inc, b_dec, b_err;

  sensor_direction_decoder dut (
    .clkup(clkup),
    .reset(reset),
    .sens_a(sens_a),
    .sens_b(sens_b),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .up_dn(up_dn),
    .busy(busy),
    .err_pulse(err_pulse)
  );

  always #5 clkup = ~clkup;

  always @(negedge clkup) begin
    if (inc_pulse === 1'b1) n_inc++;
    if (dec_pulse === 1'b1) n_dec++;
    if (err_pulse === 1'b1) n_err++;
    if ((32'(inc_pulse) + 32'(dec_pulse) + 32'(err_pulse)) > 1) n_multi++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkup);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_inc = n_inc;
    b_dec = n_dec;
    b_err = n_err;
  endtask

  initial begin
    reset  = 1'b1;
    sens_a = 1'b0;
    sens_b = 1'b0;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_inc", 32'(inc_pulse), 0);
    check("rst_dec", 32'(dec_pulse), 0);
    check("rst_err", 32'(err_pulse), 0);
    check("rst_updn", 32'(up_dn), 1);
    reset = 1'b0;
    tick(2);

    // Exit: B, then A, B clears, A clears.
    snap();
    sens_b = 1'b1;
    tick(6);
    check("exit_latency", 32'(busy), 0);
    tick(1);
    check("exit_b1_busy", 32'(busy), 1);
    tick(3);
    sens_a = 1'b1;
    tick(10);
    sens_b = 1'b0;
    tick(10);
    sens_a = 1'b0;
    tick(6);
    check("exit_early", 32'(dec_pulse), 0);
    tick(1);
    check("exit_pulse", 32'(dec_pulse), 1);
    check("exit_updn", 32'(up_dn), 0);
    check("exit_idle", 32'(busy), 0);
    tick(1);
    check("exit_width", 32'(dec_pulse), 0);
    tick(2);
    check("exit_ndec", 32'(n_dec - b_dec), 1);
    check("exit_ninc", 32'(n_inc - b_inc), 0);
    check("exit_nerr", 32'(n_err - b_err), 0);

    // Entry: A, then B, A clears, B clears.
    snap();
    sens_a = 1'b1;
    tick(6);
    check("entry_latency", 32'(busy), 0);
    tick(1);
    check("entry_a1_busy", 32'(busy), 1);
    tick(3);
    sens_b = 1'b1;
    tick(10);
    sens_a = 1'b0;
    tick(10);
    sens_b = 1'b0;
    // Fall is captured on the next edge; pulse lands 6 edges after that.
    tick(6);
    check("entry_early", 32'(inc_pulse), 0);
    check("entry_busy", 32'(busy), 1);
    tick(1);
    check("entry_pulse", 32'(inc_pulse), 1);
    check("entry_updn", 32'(up_dn), 1);
    check("entry_idle", 32'(busy), 0);
    tick(1);
    check("entry_width", 32'(inc_pulse), 0);
    tick(2);
    check("entry_ninc", 32'(n_inc - b_inc), 1);
    check("entry_ndec", 32'(n_dec - b_dec), 0);
    check("entry_nerr", 32'(n_err - b_err), 0);

    // Glitch: 3-cycle blip on A is filtered out.
    snap();
    sens_a = 1'b1;
    tick(3);
    sens_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check("glitch_busy", 32'(busy), 0);
    end
    check("glitch_fa", 32'(dut.fa), 0);
    check("glitch_npulse", 32'((n_inc - b_inc) + (n_dec - b_dec)
                               + (n_err - b_err)), 0);

    // Back-out: A only, then A clears.
    snap();
    sens_a = 1'b1;
    tick(7);
    check("back_a1", 32'(busy), 1);
    tick(3);
    sens_a = 1'b0;
    tick(6);
    check("back_still", 32'(busy), 1);
    tick(1);
    check("back_idle", 32'(busy), 0);
    tick(3);
    check("back_ninc", 32'(n_inc - b_inc), 0);
    check("back_ndec", 32'(n_dec - b_dec), 0);
    check("back_nerr", 32'(n_err - b_err), 0);

    // Timeout: both beams held in AB_A.
    snap();
    sens_a = 1'b1;
    tick(10);
    sens_b = 1'b1;
    tick(7);
    check("to_aba", 32'(busy), 1);
    tick(63);
    check("to_early", 32'(err_pulse), 0);
    check("to_nerr0", 32'(n_err - b_err), 0);
    tick(1);
    check("to_pulse", 32'(err_pulse), 1);
    tick(1);
    check("to_width", 32'(err_pulse), 0);
    tick(8);
    check("to_wait_busy", 32'(busy), 1);
    sens_a = 1'b0;
    sens_b = 1'b0;
    tick(6);
    check("to_wait_hold", 32'(busy), 1);
    tick(1);
    check("to_idle", 32'(busy), 0);
    tick(2);
    check("to_nerr", 32'(n_err - b_err), 1);
    check("to_ninc", 32'(n_inc - b_inc), 0);
    check("to_ndec", 32'(n_dec - b_dec), 0);

    // Another exit so up_dn is 0 before the reset test.
    sens_b = 1'b1;
    tick(10);
    sens_a = 1'b1;
    tick(10);
    sens_b = 1'b0;
    tick(10);
    sens_a = 1'b0;
    tick(10);
    check("exit2_updn", 32'(up_dn), 0);

    // Reset while in B2.
    snap();
    sens_a = 1'b1;
    tick(10);
    sens_b = 1'b1;
    tick(10);
    sens_a = 1'b0;
    tick(8);
    check("rmid_b2", 32'(busy), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rmid_busy", 32'(busy), 0);
    check("rmid_updn", 32'(up_dn), 1);
    check("rmid_inc", 32'(inc_pulse), 0);
    check("rmid_dec", 32'(dec_pulse), 0);
    check("rmid_err", 32'(err_pulse), 0);
    check("rmid_fb", 32'(dut.fb), 0);
    // B still high: full latency again before the FSM sees it.
    tick(6);
    check("rmid_relat", 32'(busy), 0);
    tick(1);
    check("rmid_b1", 32'(busy), 1);
    sens_b = 1'b0;
    tick(7);
    check("rmid_idle", 32'(busy), 0);
    tick(2);
    check("rmid_ninc", 32'(n_inc - b_inc), 0);
    check("rmid_ndec", 32'(n_dec - b_dec), 0);
    check("rmid_nerr", 32'(n_err - b_err), 0);

    check("pulse_excl", 32'(n_multi), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
